// File: rtl/i2c_codec_writer_if.sv
// rtl/i2c_codec_writer_if.sv - command/status bundle between the codec sequencer and the I2C writer
interface i2c_codec_writer_if;
  logic [23:0] iDATA;
  logic        iGO;
  logic        oEND;
  logic        oACK;
  logic        oBUSY;

  modport master (output iDATA, output iGO, input oEND, input oACK, input oBUSY);
  modport slave  (input iDATA, input iGO, output oEND, output oACK, output oBUSY);
endinterface

// File: rtl/i2c_codec_writer.sv
// rtl/i2c_codec_writer.sv - bit-level I2C write master for one 24-bit word (optional I2C_WR_ABORT_ON_NACK_EN)
module i2c_codec_writer #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  i2c_codec_writer_if.slave bus,
  output logic             I2C_SCLK,
  inout  wire              I2C_SDAT
);
  localparam int DIV   = CLK_FREQ / (4 * I2C_FREQ);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} stateT;

  stateT            stateQ, stateD;
  logic [1:0]       goSync, sdaSync;
  logic             goPrev;
  logic [DIV_W-1:0] divCnt;
  logic [1:0]       quarter;
  logic [3:0]       bitIdx;
  logic [1:0]       byteIdx;
  logic [23:0]      dataReg;
  logic             ackReg;
  logic             sclOut, sdaLow;

  wire goRise    = goSync[1] & ~goPrev;
  wire idleLike  = (stateQ == IDLE) || (stateQ == DONE);
  wire startXfer = idleLike && goRise;
  wire tick      = (divCnt == DIV_W'(DIV - 1));
  wire slotEnd   = tick && (quarter == 2'd3);
  wire ackSlot   = (bitIdx == 4'd8);
  wire lastSlot  = ackSlot && (byteIdx == 2'd2);

  logic abortNow;
`ifdef I2C_WR_ABORT_ON_NACK_EN
  // A NACK already latched by the end of an ack slot cuts the transfer short.
  assign abortNow = ackSlot && ackReg;
`else
  assign abortNow = 1'b0;
`endif

  // Two-flop synchronisers for the start request and the SDA readback, plus iGO edge history.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      goSync  <= 2'b00;
      sdaSync <= 2'b11;
      goPrev  <= 1'b0;
    end else begin
      goSync  <= {goSync[0], bus.iGO};
      sdaSync <= {sdaSync[0], I2C_SDAT};
      goPrev  <= goSync[1];
    end
  end

  // State register; async reset drops straight to IDLE so the bus is released at once.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) stateQ <= IDLE;
    else         stateQ <= stateD;
  end

  // Next state and per-quarter SCL/SDA waveform.
  always_comb begin
    stateD = stateQ;
    sclOut = 1'b1;
    sdaLow = 1'b0;
    case (stateQ)
      IDLE, DONE: begin
        if (goRise) stateD = START;
      end
      START: begin
        sclOut = (quarter != 2'd3);
        sdaLow = quarter[1];
        if (slotEnd) stateD = BITS;
      end
      BITS: begin
        sclOut = quarter[0] ^ quarter[1];
        sdaLow = !ackSlot && !dataReg[23];
        if (slotEnd && (lastSlot || abortNow)) stateD = STOP;
      end
      STOP: begin
        sclOut = (quarter != 2'd0);
        sdaLow = !quarter[1];
        if (slotEnd) stateD = DONE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Quarter-bit timebase, bit/byte position, shift register and sticky NACK flag.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      divCnt  <= '0;
      quarter <= 2'd0;
      bitIdx  <= 4'd0;
      byteIdx <= 2'd0;
      dataReg <= 24'd0;
      ackReg  <= 1'b0;
    end else if (startXfer) begin
      divCnt  <= '0;
      quarter <= 2'd0;
      bitIdx  <= 4'd0;
      byteIdx <= 2'd0;
      dataReg <= bus.iDATA;
      ackReg  <= 1'b0;
    end else if (!idleLike) begin
      divCnt <= tick ? '0 : divCnt + DIV_W'(1);
      if (tick) quarter <= quarter + 2'd1;
      if (stateQ == BITS && tick && quarter == 2'd1 && ackSlot && sdaSync[1])
        ackReg <= 1'b1;
      if (stateQ == BITS && slotEnd) begin
        if (ackSlot) begin
          bitIdx  <= 4'd0;
          byteIdx <= byteIdx + 2'd1;
        end else begin
          bitIdx  <= bitIdx + 4'd1;
          dataReg <= {dataReg[22:0], 1'b0};
        end
      end
    end
  end

  assign bus.oEND  = (stateQ == DONE);
  assign bus.oBUSY = (stateQ == START) || (stateQ == BITS) || (stateQ == STOP);
  assign bus.oACK  = ackReg;
  assign I2C_SCLK  = sclOut;
  assign I2C_SDAT  = sdaLow ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_codec_writer.sv
// tb/tb_i2c_codec_writer.sv - randomized self-checking bench for i2c_codec_writer
module tb_i2c_codec_writer;
  localparam int CLK_FREQ = 50000000;
  localparam int I2C_FREQ = 2500000;
  localparam int DIV      = CLK_FREQ / (4 * I2C_FREQ);

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  logic sclLine;
  logic slaveLow = 1'b0;
  wire  sdaBus;

  i2c_codec_writer_if bus();

  pullup (sdaBus);
  assign sdaBus = slaveLow ? 1'b0 : 1'bz;

  i2c_codec_writer #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .bus(bus), .I2C_SCLK(sclLine), .I2C_SDAT(sdaBus)
  );

  always #5 iCLK = ~iCLK;

  int cycle = 0;
  always @(posedge iCLK) cycle <= cycle + 1;

  int errCount = 0;
  int checkCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and slave: decodes start/stop, samples bits on SCL rise, drives ACKs per ackMask.
  logic       prevScl = 1'b1, prevSda = 1'b1, monSda;
  int         starts = 0, stops = 0, periodErr = 0, bitCnt = 0, lastRise = -1;
  logic [2:0] ackMask = 3'b111;
  logic       monBits[$];

  always @(negedge iCLK) begin
    monSda = sdaBus;
    if (!iRST_N) begin
      slaveLow = 1'b0;
      lastRise = -1;
    end else begin
      if (sclLine && prevScl && prevSda && !monSda) begin
        starts++;
        bitCnt = 0;
        monBits.delete();
        lastRise = -1;
        slaveLow = 1'b0;
      end
      if (sclLine && prevScl && !prevSda && monSda) stops++;
      if (sclLine && !prevScl) begin
        monBits.push_back(monSda);
        if (lastRise >= 0 && cycle - lastRise != 4 * DIV) periodErr++;
        lastRise = cycle;
        bitCnt++;
      end
      if (!sclLine && prevScl) begin
        if (bitCnt % 9 == 8 && bitCnt < 27 && ackMask[bitCnt / 9]) slaveLow = 1'b1;
        else slaveLow = 1'b0;
      end
    end
    prevScl = sclLine;
    prevSda = monSda;
  end

  // Reference: expected serial stream, NACK result and completion latency from the word and ack pattern.
  task automatic modelXfer(input logic [23:0] w, input logic [2:0] am,
                           output logic [31:0] vec, output int n, output logic ack, output int lat);
    bit stop;
    vec = '0; n = 0; ack = 1'b0; stop = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (!stop) begin
        for (int i = 0; i < 8; i++) begin
          vec = {vec[30:0], w[23 - 8 * b - i]};
          n++;
        end
        vec = {vec[30:0], ~am[b]};
        n++;
        if (!am[b]) begin
          ack = 1'b1;
`ifdef I2C_WR_ABORT_ON_NACK_EN
          stop = 1'b1;
`endif
        end
      end
    end
    lat = 3 + (1 + n + 1) * 4 * DIV;
  endtask

  task automatic doXfer(input logic [23:0] w, input logic [2:0] am, input bit corrupt);
    logic [31:0] expVec, obsVec;
    int n, lat, t0, el, busyAt, endAt;
    logic expAck;
    modelXfer(w, am, expVec, n, expAck, lat);
    bus.iGO = 1'b0;
    repeat (5) @(posedge iCLK);
    bus.iDATA = w;
    ackMask = am;
    starts = 0; stops = 0; periodErr = 0;
    @(posedge iCLK); #1;
    bus.iGO = 1'b1;
    t0 = cycle;
    busyAt = -1; endAt = -1;
    for (int k = 0; k < lat + 100; k++) begin
      @(negedge iCLK);
      el = cycle - t0;
      if (busyAt < 0 && bus.oBUSY) busyAt = el;
      if (corrupt && el == 100) bus.iDATA = 24'hFFFFFF;
      if (el > 3 && bus.oEND) begin
        endAt = el;
        break;
      end
    end
    obsVec = '0;
    for (int i = 0; i < n; i++) obsVec = {obsVec[30:0], (i < monBits.size()) ? monBits[i] : 1'bx};
    checkVal("busy_latency", busyAt, 3);
    checkVal("end_latency", endAt, lat);
    checkVal("oACK", {31'd0, bus.oACK}, {31'd0, expAck});
    checkVal("oBUSY_done", {31'd0, bus.oBUSY}, 0);
    checkVal("scl_rises", monBits.size(), n + 1);
    checkVal("bit_stream", obsVec, expVec);
    checkVal("start_cond", starts, 1);
    checkVal("stop_cond", stops, 1);
    checkVal("scl_period", periodErr, 0);
  endtask

  initial begin
    int t0, el;
    bit sawLow;
    bus.iGO = 1'b0;
    bus.iDATA = 24'd0;
    repeat (3) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    repeat (10) @(posedge iCLK);
    @(negedge iCLK);
    checkVal("rst_scl", {31'd0, sclLine}, 1);
    checkVal("rst_sda", {31'd0, sdaBus}, 1);
    checkVal("rst_oEND", {31'd0, bus.oEND}, 0);
    checkVal("rst_oACK", {31'd0, bus.oACK}, 0);
    checkVal("rst_oBUSY", {31'd0, bus.oBUSY}, 0);

    doXfer(24'h341E00, 3'b111, 1'b0);
    doXfer(24'h341E00, 3'b101, 1'b0);

    // iGO left high after completion must not retrigger; a fresh rise does, with oEND falling 3 cycles later.
    repeat (200) @(posedge iCLK);
    @(negedge iCLK);
    checkVal("hold_oEND", {31'd0, bus.oEND}, 1);
    checkVal("hold_oBUSY", {31'd0, bus.oBUSY}, 0);
    checkVal("hold_starts", starts, 1);
    bus.iGO = 1'b0;
    repeat (1000) @(posedge iCLK);
    #1 bus.iGO = 1'b1;
    t0 = cycle;
    for (int k = 0; k < 5; k++) begin
      @(negedge iCLK);
      el = cycle - t0;
      if (el == 2) checkVal("oEND_before_fall", {31'd0, bus.oEND}, 1);
      if (el == 3) checkVal("oEND_fall", {31'd0, bus.oEND}, 0);
    end
    for (int k = 0; k < 116 * DIV + 100 && !bus.oEND; k++) @(negedge iCLK);
    checkVal("retrigger_done", {31'd0, bus.oEND}, 1);

    doXfer(24'h341E00, 3'b111, 1'b1);

    for (int r = 0; r < 6; r++) doXfer(24'($urandom), 3'($urandom_range(0, 7)), 1'b0);

    // Reset in the middle of byte 2 while SCL is low.
    bus.iGO = 1'b0;
    repeat (5) @(posedge iCLK);
    bus.iDATA = 24'($urandom);
    ackMask = 3'b111;
    @(posedge iCLK); #1 bus.iGO = 1'b1;
    sawLow = 1'b0;
    for (int k = 0; k < 116 * DIV + 100; k++) begin
      @(negedge iCLK);
      if (bitCnt >= 12 && !sclLine && !slaveLow) begin
        sawLow = 1'b1;
        break;
      end
    end
    checkVal("mid_reached", {31'd0, sawLow}, 1);
    #2 iRST_N = 1'b0;
    #1;
    checkVal("async_scl", {31'd0, sclLine}, 1);
    checkVal("async_sda", {31'd0, sdaBus}, 1);
    checkVal("async_oBUSY", {31'd0, bus.oBUSY}, 0);
    bus.iGO = 1'b0;
    repeat (3) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    starts = 0;
    repeat (100) @(negedge iCLK);
    checkVal("post_rst_oBUSY", {31'd0, bus.oBUSY}, 0);
    checkVal("post_rst_oEND", {31'd0, bus.oEND}, 0);
    checkVal("post_rst_oACK", {31'd0, bus.oACK}, 0);
    checkVal("post_rst_scl", {31'd0, sclLine}, 1);
    checkVal("post_rst_sda", {31'd0, sdaBus}, 1);
    checkVal("post_rst_starts", starts, 0);

    doXfer(24'h341E00, 3'b011, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
